dmem_stage: RTL
===============

# dmem_stage

Data-memory pipeline stage of the Venus core. It sits between `execute` and `writeback` and fills the data-memory slot in the core top. The stage consumes EX results over the v/stall handshake and services loads and stores against an internal word-addressed data RAM. It forwards results, or loaded words, to WB over the same handshake.

## Interface
- `DEPTH_LOG2`, default 16: log2 of the data RAM depth in words (64k words); only `addr_i[DEPTH_LOG2-1:0]` is used.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `v_i` input 1: EX presents a valid operation.
- `stall_o` output 1: this stage cannot accept this cycle.
- `wb_i` input 1: operation writes a register.
- `rd_num_i` input `W_RD: destination register number.
- `rd_data_i` input `WORD: ALU result, passed through for non-load ops.
- `mem_op_i` input 2: 00 none, 01 load, 10 store, 11 treated as none.
- `addr_i` input `ADDR: word address for load/store.
- `st_data_i` input `WORD: store data.
- `v_o` output 1: valid result to WB.
- `stall_i` input 1: WB cannot accept.
- `wb_o` output 1: register write-enable to WB.
- `rd_num_o` output `W_RD: destination register to WB.
- `rd_data_o` output `WORD: result/loaded word to WB.

## Operation
- Handshake: a transfer occurs on a rising edge where valid=1 and stall=0, on both sides.
  - Upstream accept: `acc = v_i & ~stall_o`.
  - Downstream consume: `v_o & ~stall_i`.
- `stall_o = (state == LOAD) | (v_o & stall_i)`. It is combinational and does not depend on `v_i`.
- State machine has two states, IDLE and LOAD.
  - IDLE, acc, op none/11: output register <= {v=1, wb=wb_i, rd_num_i, rd_data_i}; stay IDLE.
  - IDLE, acc, store: `mem[addr_i] <= st_data_i` on that edge; output register <= {1, wb=0, rd_num_i, rd_data_i}. A store is still a token to WB but never writes a register. Stay IDLE.
  - IDLE, acc, load: synchronous RAM read of `mem[addr_i]` issued on that edge. Latch wb_i and rd_num_i. Set v_o <= 0. Go to LOAD.
  - LOAD: exactly one cycle, always followed by IDLE. On exit, output register <= {1, wb_latched, rd_num_latched, ram_q}.
  - No acc and consume: v_o <= 0; other output fields hold their last value.
  - No acc and no consume: output register holds.
- Read-after-write: a store accepted at edge E followed by a load accepted at E+1 or later returns the stored data.
- Address bits above DEPTH_LOG2 are ignored, so addresses wrap modulo 2^DEPTH_LOG2.
- Asynchronous reset, including mid-LOAD:
  - state = IDLE, v_o = 0, wb_o = 0, rd_num_o = 0, rd_data_o = 0.
  - Any in-flight load is discarded.
  - RAM contents are not cleared; a store already committed on a prior edge persists.

## Timing
- Non-memory op and store: 1-cycle latency. Accept at edge E, `v_o` = 1 from E.
- Load: 2-cycle latency. Accept at E, `stall_o` = 1 during E..E+1, `v_o` = 1 from E+1.
- Throughput:
  - One non-load op per cycle while WB does not stall.
  - Loads cost one bubble cycle each.
- Downstream stall holds all outputs stable and asserts `stall_o` in the same cycle.
- Simultaneous consume and accept on one edge is legal and loses no data.
- Reset values: `stall_o` = `stall_i`&0 = 0 after reset, since v_o = 0 and state is IDLE.

## Test plan
- Reset mid-LOAD: pulse rst while in LOAD -> `v_o`=0 and `stall_o`=0 immediately, with no clock edge needed; next accepted op behaves normally.
- Passthrough stream: 4 back-to-back non-memory ops, rd_data 1..4, `stall_i`=0 -> `v_o`=1 on 4 consecutive cycles with rd_data_o 1,2,3,4; `stall_o` never high.
- Store then load: store 0xDEADBEEF to addr 0x0010, then load addr 0x0010 to r5 with wb_i=1:
  - store token has wb_o=0;
  - `stall_o`=1 for 1 cycle;
  - then v_o=1, wb_o=1, rd_num_o=5, rd_data_o=0xDEADBEEF.
- Downstream stall: hold `stall_i`=1 for 3 cycles while v_o=1 with data 0x55 -> outputs unchanged, `stall_o`=1 for all 3 cycles, no upstream op lost; releases on the next cycle.
- Address wrap: store 0x1234 to addr 0x0001_0003, then load 0x0003 -> returns 0x1234.
- Opcode 11 with wb_i=1, rd_data 0x77 -> behaves as none: v_o=1, wb_o=1, rd_data_o=0x77; memory unchanged.

Source files
------------

// File: rtl/dmem_stage_if.sv
// Handshake bundle between execute, the data-memory stage and writeback.
// The slave modport is the stage itself; the master modport is the
// surrounding core (EX drives the _i side, WB consumes the _o side).
interface dmem_stage_if #(
   parameter int W_RD = 5,
   parameter int WORD = 32,
   parameter int ADDR = 32
);
   // upstream (EX -> stage)
   logic            v_i;
   logic            stall_o;
   logic            wb_i;
   logic [W_RD-1:0] rd_num_i;
   logic [WORD-1:0] rd_data_i;
   logic [1:0]      mem_op_i;
   logic [ADDR-1:0] addr_i;
   logic [WORD-1:0] st_data_i;

   // downstream (stage -> WB)
   logic            v_o;
   logic            stall_i;
   logic            wb_o;
   logic [W_RD-1:0] rd_num_o;
   logic [WORD-1:0] rd_data_o;

   modport slave (
      input  v_i, wb_i, rd_num_i, rd_data_i, mem_op_i, addr_i, st_data_i,
      input  stall_i,
      output stall_o, v_o, wb_o, rd_num_o, rd_data_o
   );

   modport master (
      output v_i, wb_i, rd_num_i, rd_data_i, mem_op_i, addr_i, st_data_i,
      output stall_i,
      input  stall_o, v_o, wb_o, rd_num_o, rd_data_o
   );
endinterface

// File: rtl/dmem_stage.sv
// Data-memory pipeline stage: passes ALU results through to WB, commits
// stores into an internal word-addressed RAM, and services loads with a
// one-cycle synchronous RAM read (one bubble per load).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a new op; output register holds last result/token
// LOAD  | RAM read in flight; upstream stalled, result presented on exit
module dmem_stage #(
   parameter int DEPTH_LOG2 = 16,
   parameter int W_RD       = 5,
   parameter int WORD       = 32,
   parameter int ADDR       = 32
) (
   input  logic            clk,
   input  logic            rst,
   dmem_stage_if.slave     bus
);

   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      LOAD = 1'b1
   } state_t;

   state_t                state_q;
   logic                  v_q;
   logic                  wb_q;
   logic [W_RD-1:0]       rd_num_q;
   logic [WORD-1:0]       rd_data_q;
   logic                  wb_lat_q;
   logic [W_RD-1:0]       rd_lat_q;
   logic [WORD-1:0]       ram_q;
   logic [WORD-1:0]       mem_q [2**DEPTH_LOG2];

   logic                  acc_d;
   logic                  consume_d;
   logic                  is_load_d;
   logic                  is_store_d;
   logic [DEPTH_LOG2-1:0] waddr_d;

   // Only the low address bits index the RAM; upper bits wrap away.
   generate
      if (ADDR > DEPTH_LOG2) begin : g_addr_hi
         logic unused_addr_hi;
         assign unused_addr_hi = ^bus.addr_i[ADDR-1:DEPTH_LOG2];
      end
   endgenerate

   assign waddr_d    = bus.addr_i[DEPTH_LOG2-1:0];
   assign is_load_d  = (bus.mem_op_i == OP_LOAD);
   assign is_store_d = (bus.mem_op_i == OP_STORE);

   // Stall never looks at v_i so EX can use it without a combinational loop.
   assign bus.stall_o = (state_q == LOAD) | (v_q & bus.stall_i);
   assign acc_d       = bus.v_i & ~bus.stall_o;
   assign consume_d   = v_q & ~bus.stall_i;

   assign bus.v_o       = v_q;
   assign bus.wb_o      = wb_q;
   assign bus.rd_num_o  = rd_num_q;
   assign bus.rd_data_o = rd_data_q;

   // Data RAM: store writes and load reads on the accepting edge; not reset.
   always_ff @(posedge clk) begin
      if (acc_d && (state_q == IDLE)) begin
         if (is_store_d) begin
            mem_q[waddr_d] <= bus.st_data_i;
         end
         if (is_load_d) begin
            ram_q <= mem_q[waddr_d];
         end
      end
   end

   // Control FSM with registered WB-side outputs and latched load metadata.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         v_q       <= 1'b0;
         wb_q      <= 1'b0;
         rd_num_q  <= '0;
         rd_data_q <= '0;
         wb_lat_q  <= 1'b0;
         rd_lat_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (acc_d) begin
                  if (is_load_d) begin
                     // Result not ready yet; the output slot goes empty.
                     v_q      <= 1'b0;
                     wb_lat_q <= bus.wb_i;
                     rd_lat_q <= bus.rd_num_i;
                     state_q  <= LOAD;
                  end else begin
                     // Stores still travel to WB as a token, but never write.
                     v_q       <= 1'b1;
                     wb_q      <= is_store_d ? 1'b0 : bus.wb_i;
                     rd_num_q  <= bus.rd_num_i;
                     rd_data_q <= bus.rd_data_i;
                  end
               end else if (consume_d) begin
                  v_q <= 1'b0;
               end
            end
            LOAD: begin
               // v_q is already 0 here, so WB cannot be holding us off.
               v_q       <= 1'b1;
               wb_q      <= wb_lat_q;
               rd_num_q  <= rd_lat_q;
               rd_data_q <= ram_q;
               state_q   <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               v_q     <= 1'b0;
            end
         endcase
      end
   end

endmodule
